fsm_urt_rx: RTL

Control state machine of the UART receiver. It tracks one serial frame (start, DATA_W data bits, optional parity, stop) using an internal oversampling edge/bit counter. It drives the one-cycle enable pulses for the sampler, start-check, deserializer, parity-check and stop-check stages, consumes their error flags, and raises `data_valid_FSM` for each accepted frame.

---
 rtl/urt_rx_pkg.sv | 22 ++
 rtl/edge_bit_counter_urt_rx.sv | 52 +++++
 rtl/fsm_urt_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/urt_rx_pkg.sv
// Shared definitions for the UART receiver control path: state encoding,
// legal oversampling range and the mid-bit check-point helper.
package urt_rx_pkg;

    typedef enum logic [2:0] {
        URT_IDLE   = 3'd0,
        URT_START  = 3'd1,
        URT_DATA   = 3'd2,
        URT_PARITY = 3'd3,
        URT_STOP   = 3'd4
    } urt_state_e;

    localparam int unsigned MIN_PRESCALE = 8;
    localparam int unsigned MAX_PRESCALE = 32;

    // Oversample index at which a bit is checked: two ticks past the centre,
    // giving the line time to settle after the nominal mid-bit point.
    function automatic logic [7:0] chk_offset(input logic [7:0] prescale);
        return (prescale >> 1) + 8'd2;
    endfunction

endpackage

// File: rtl/edge_bit_counter_urt_rx.sv
// Oversampling edge counter and frame bit counter for the UART receiver.
// Both counters sit at zero while disabled; the edge counter wraps at
// prescale-1 and each wrap advances the bit counter.
module edge_bit_counter_urt_rx
    import urt_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]         bit_cnt_q,  bit_cnt_d;
    logic               last_edge;

    assign last_edge = (edge_cnt_q == prescale - PRESC_W'(1));

    // Next count: clear when disabled, otherwise advance and wrap at end of bit.
    always_comb begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (enable) begin
            if (last_edge) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESC_W'(1);
                bit_cnt_d  = bit_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/fsm_urt_rx.sv
// UART receiver frame-control FSM.
// Tracks start / data / optional parity / stop of one frame, pulses the
// check-stage enables at the mid-bit check point and flags accepted frames.
// Optional build macro URT_RX_FRAME_ERR_EN adds frm_err_FSM, a one-cycle
// pulse for every rejected frame (start glitch, parity or stop error).
//
//   state  | meaning
//   IDLE   | line idle, counters cleared, waiting for a low level
//   START  | start bit; start check at M, glitch decision at E
//   DATA   | DATA_W data bits; deserializer strobe at M of each bit
//   PARITY | parity bit (only if latched on); parity check at M
//   STOP   | stop check at M, verdict at M+1, then back to IDLE early
module fsm_urt_rx
    import urt_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK_FSM,
    input  logic               RST_FSM,
    input  logic               RX_IN_FSM,
    input  logic               PAR_EN_FSM,
    input  logic [PRESC_W-1:0] Prescale_FSM,
    input  logic               strt_glitch_FSM,
    input  logic               par_err_FSM,
    input  logic               stp_err_FSM,
    output logic               dat_samp_en_FSM,
    output logic               strt_chk_en_FSM,
    output logic               deser_en_FSM,
    output logic               par_chk_en_FSM,
    output logic               stp_chk_en_FSM,
    output logic               data_valid_FSM,
    output logic [PRESC_W-1:0] edge_cnt_FSM,
    output logic [3:0]         bit_cnt_FSM
`ifdef URT_RX_FRAME_ERR_EN
    ,
    output logic               frm_err_FSM
`endif
);

    localparam logic [2:0] IDLE   = URT_IDLE;
    localparam logic [2:0] START  = URT_START;
    localparam logic [2:0] DATA   = URT_DATA;
    localparam logic [2:0] PARITY = URT_PARITY;
    localparam logic [2:0] STOP   = URT_STOP;

    logic [2:0]         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic               samp_en_q, samp_en_d;
    logic               strt_chk_q, strt_chk_d;
    logic               deser_q, deser_d;
    logic               par_chk_q, par_chk_d;
    logic               stp_chk_q, stp_chk_d;
    logic               stp_eval_q, stp_eval_d;

    logic [PRESC_W-1:0] presc_clamped;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic [PRESC_W-1:0] pt_mid, pt_mid_m1, pt_end;
    logic               at_mid_m1, at_mid, at_end;
    logic               frame_start;
    logic               frame_err;
    logic               cnt_en;

    assign pt_mid    = PRESC_W'(chk_offset(8'(presc_q)));
    assign pt_mid_m1 = pt_mid - PRESC_W'(1);
    assign pt_end    = presc_q - PRESC_W'(1);

    assign at_mid_m1 = (edge_cnt == pt_mid_m1);
    assign at_mid    = (edge_cnt == pt_mid);
    assign at_end    = (edge_cnt == pt_end);

    assign frame_start = (state_q == IDLE) && !RX_IN_FSM;

    // An out-of-range prescale would break the check-point arithmetic, so
    // the latched ratio is forced even and clamped into the legal window.
    always_comb begin
        presc_clamped = Prescale_FSM & ~PRESC_W'(1);
        if (Prescale_FSM < PRESC_W'(MIN_PRESCALE)) begin
            presc_clamped = PRESC_W'(MIN_PRESCALE);
        end else if (Prescale_FSM > PRESC_W'(MAX_PRESCALE)) begin
            presc_clamped = PRESC_W'(MAX_PRESCALE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN_FSM) state_d = START;
            START:   if (at_end) state_d = strt_glitch_FSM ? IDLE : DATA;
            DATA:    if (at_end && (bit_cnt == 4'(DATA_W))) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (at_end) state_d = STOP;
            STOP:    if (stp_eval_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame configuration latch and registered strobes; each enable is decoded
    // one tick early so the flop output lines up with the check point M.
    always_comb begin
        presc_d    = frame_start ? presc_clamped : presc_q;
        par_en_d   = frame_start ? PAR_EN_FSM    : par_en_q;
        samp_en_d  = (state_d != IDLE);
        strt_chk_d = (state_q == START)  && at_mid_m1;
        deser_d    = (state_q == DATA)   && at_mid_m1;
        par_chk_d  = (state_q == PARITY) && at_mid_m1;
        stp_chk_d  = (state_q == STOP)   && at_mid_m1;
        stp_eval_d = (state_q == STOP)   && at_mid;
    end

    // The counters must read zero on the first START cycle and on entry to
    // IDLE, so they only run while the FSM both is and stays inside a frame.
    assign cnt_en = (state_q != IDLE) && (state_d != IDLE);

    edge_bit_counter_urt_rx #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .clk      (CLK_FSM),
        .rst_n    (RST_FSM),
        .enable   (cnt_en),
        .prescale (presc_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    // State, frame configuration and strobe registers.
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            state_q    <= IDLE;
            presc_q    <= PRESC_W'(MIN_PRESCALE);
            par_en_q   <= 1'b0;
            samp_en_q  <= 1'b0;
            strt_chk_q <= 1'b0;
            deser_q    <= 1'b0;
            par_chk_q  <= 1'b0;
            stp_chk_q  <= 1'b0;
            stp_eval_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            samp_en_q  <= samp_en_d;
            strt_chk_q <= strt_chk_d;
            deser_q    <= deser_d;
            par_chk_q  <= par_chk_d;
            stp_chk_q  <= stp_chk_d;
            stp_eval_q <= stp_eval_d;
        end
    end

    // The verdict cycle (STOP, edge M+1) is a registered strobe; the check
    // stages only produce their result in that same cycle, so the accept
    // pulse is that strobe gated by the returned error flags.
    assign frame_err = stp_err_FSM | (par_en_q & par_err_FSM);

    assign dat_samp_en_FSM = samp_en_q;
    assign strt_chk_en_FSM = strt_chk_q;
    assign deser_en_FSM    = deser_q;
    assign par_chk_en_FSM  = par_chk_q;
    assign stp_chk_en_FSM  = stp_chk_q;
    assign data_valid_FSM  = stp_eval_q & ~frame_err;
    assign edge_cnt_FSM    = edge_cnt;
    assign bit_cnt_FSM     = bit_cnt;

`ifdef URT_RX_FRAME_ERR_EN
    logic strt_end_q, strt_end_d;

    // Registered marker for the last START tick, where a glitch is rejected.
    always_comb begin
        strt_end_d = (state_q == START) && (edge_cnt == presc_q - PRESC_W'(2));
    end

    // Start-end marker register.
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            strt_end_q <= 1'b0;
        end else begin
            strt_end_q <= strt_end_d;
        end
    end

    assign frm_err_FSM = (strt_end_q & strt_glitch_FSM) | (stp_eval_q & frame_err);
`endif

endmodule
